add_32_serial: RTL and testbench

Multi-cycle 32-bit adder: the addition counterpart of the datapath's 32-bit ripple-borrow subtractor. It computes {cout, sum} = in0 + in1 + cin a few bits per clock, using a STEP-bit slice adder and a registered carry. It sits beside the subtractor in the CPU arithmetic unit and is driven by the ALU controller through a start/busy/done handshake, giving an area-reduced add path.

---
 rtl/add_32_serial.sv | 76 +++++++
 tb/tb_add_32_serial.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/add_32_serial.sv
// add_32_serial: multi-cycle adder computing {cout, sum} = in0 + in1 + cin STEP bits per clock
module add_32_serial #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  if (STEP < 1 || WIDTH % STEP != 0) begin : g_bad_step
    $error("add_32_serial: STEP must divide WIDTH");
  end
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state;
  logic [WIDTH-1:0] a, b, p, p_next;
  logic             c;
  logic [CW-1:0]    cnt;
  logic [STEP:0]    slice;
  logic             last;
  // one STEP-bit slice add on the low operand bits plus the carry flop; the new slice enters the partial result at the top
  always_comb begin
    slice  = {1'b0, a[STEP-1:0]} + {1'b0, b[STEP-1:0]} + {{STEP{1'b0}}, c};
    p_next = WIDTH'({slice[STEP-1:0], p} >> STEP);
    last   = cnt == CW'(N - 1);
  end
  // control FSM with shift datapath; outputs only update on the completing step
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      p     <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a     <= in0;
          b     <= in1;
          c     <= cin;
          p     <= '0;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= RUN;
        end
      end else begin
        a   <= a >> STEP;
        b   <= b >> STEP;
        c   <= slice[STEP];
        p   <= p_next;
        cnt <= cnt + 1'b1;
        if (last) begin
          sum   <= p_next;
          cout  <= slice[STEP];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_add_32_serial.sv
// tb_add_32_serial: directed vector and handshake-sequence checks for add_32_serial
module tb_add_32_serial;
  logic        clk = 1'b0;
  logic        reset, start, cin, cout, busy, done;
  logic [31:0] in0, in1, sum;
  int          checks = 0;
  int          errors = 0;
  int          lat;
  add_32_serial dut (
    .clk(clk), .reset(reset), .start(start), .in0(in0), .in1(in1), .cin(cin),
    .sum(sum), .cout(cout), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] es;
    logic        ec;
  } vec_t;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic op(input logic [31:0] x, input logic [31:0] y, input logic ci);
    in0 = x;
    in1 = y;
    cin = ci;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in0 = ~x;
    in1 = ~y;
    cin = ~ci;
    chk("busy_after_accept", {63'b0, busy}, 64'd1);
    lat = -1;
    for (int i = 0; i <= 20; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    chk("busy_at_done", {63'b0, busy}, 64'd0);
  endtask
  initial begin
    vec_t vt[7];
    int   nd, t1, t2, bad12;
    logic [31:0] s1, s2;
    vt[0] = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0};
    vt[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
    vt[2] = '{32'h80000000, 32'h80000000, 1'b1, 32'h00000001, 1'b1};
    vt[3] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
    vt[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
    vt[5] = '{32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0, 32'hFFFFFFFF, 1'b0};
    vt[6] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0};
    reset = 1'b1;
    start = 1'b1;
    in0 = 32'h1;
    in1 = 32'h1;
    cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_sum", {32'b0, sum}, 64'd0);
    chk("reset_cout", {63'b0, cout}, 64'd0);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 7; k++) begin
      op(vt[k].a, vt[k].b, vt[k].ci);
      chk($sformatf("vec%0d_latency", k), 64'(lat), 64'd8);
      chk($sformatf("vec%0d_sum", k), {32'b0, sum}, {32'b0, vt[k].es});
      chk($sformatf("vec%0d_cout", k), {63'b0, cout}, {63'b0, vt[k].ec});
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_pulse", k), {63'b0, done}, 64'd0);
    end
    in0 = 32'h1;
    in1 = 32'h1;
    cin = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0;
    s1 = '0;
    for (int t = 0; t < 20; t++) begin
      if (done) begin
        nd++;
        s1 = sum;
      end
      if (t == 3) begin
        start = 1'b1;
        in0 = 32'hFFFFFFFF;
        in1 = 32'h12345678;
        cin = 1'b1;
      end
      if (t == 4) start = 1'b0;
      @(posedge clk); #1;
    end
    chk("busy_start_dones", 64'(nd), 64'd1);
    chk("busy_start_sum", {32'b0, s1}, 64'd2);
    chk("busy_start_idle", {63'b0, busy}, 64'd0);
    in0 = 32'd5;
    in1 = 32'd7;
    cin = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    in0 = 32'd10;
    in1 = 32'd20;
    nd = 0;
    t1 = -1;
    t2 = -1;
    s1 = '0;
    s2 = '0;
    bad12 = 0;
    for (int t = 0; t < 30; t++) begin
      if (busy && done) bad12++;
      if (done) begin
        nd++;
        if (nd == 1) begin
          t1 = t;
          s1 = sum;
        end else begin
          t2 = t;
          s2 = sum;
        end
      end else if (nd == 1 && sum != 32'd12) bad12++;
      if (t == 9) start = 1'b0;
      @(posedge clk); #1;
    end
    chk("b2b_dones", 64'(nd), 64'd2);
    chk("b2b_first_at", 64'(t1), 64'd8);
    chk("b2b_spacing", 64'(t2 - t1), 64'd9);
    chk("b2b_sum1", {32'b0, s1}, 64'd12);
    chk("b2b_sum2", {32'b0, s2}, 64'd30);
    chk("b2b_hold12", 64'(bad12), 64'd0);
    op(32'd5, 32'd7, 1'b0);
    chk("pre_reset_sum", {32'b0, sum}, 64'd12);
    in0 = 32'hAAAAAAAA;
    in1 = 32'h55555555;
    cin = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_sum", {32'b0, sum}, 64'd0);
    chk("abort_cout", {63'b0, cout}, 64'd0);
    nd = 0;
    for (int t = 0; t < 12; t++) begin
      if (done) nd++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    op(32'd3, 32'd4, 1'b1);
    chk("fresh_latency", 64'(lat), 64'd8);
    chk("fresh_sum", {32'b0, sum}, 64'd8);
    chk("fresh_cout", {63'b0, cout}, 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
